theta_train_sequencer: RTL and testbench

Gamma-cycle-aligned stimulus and training scheduler for the `pst_2layer_theta` + `gamma_oscillator` datapath. It drives `input_current` and `l3_freeze` through a fixed schedule: warm-up, alternating A/B training segments, then a frozen-L3 evaluation window. At the end it samples the slot debug outputs and produces a pass/fail verdict, so self-checking regressions and on-chip self-test no longer depend on hand-timed testbench delays.

---
 rtl/theta_seq_pkg.sv | 30 +++
 rtl/gamma_phase_counter.sv | 34 +++
 rtl/theta_train_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_theta_train_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/theta_seq_pkg.sv
// rtl/theta_seq_pkg.sv - shared types, defaults and verdict helper for the theta training sequencer
//
// Contents:
//   seq_state_t  3-bit FSM state encoding (also exported on state_dbg)
//   DEF_*        default schedule lengths and verdict thresholds
//   theta_pass() unsigned strict verdict: s0 < s0max && s4 > s4min
package theta_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_WARMUP = 3'd2,
    S_TRAIN  = 3'd3,
    S_EVAL   = 3'd4,
    S_CHECK  = 3'd5
  } seq_state_t;

  localparam int DEF_WARM_CYC = 20;
  localparam int DEF_SEG_CYC  = 8;
  localparam int DEF_N_SEG    = 6;
  localparam int DEF_EVAL_CYC = 8;
  localparam int DEF_S0_MAX   = 10;
  localparam int DEF_S4_MIN   = 20;

  function automatic logic theta_pass(input logic [7:0] s0, input logic [7:0] s4,
                                      input logic [7:0] s0max, input logic [7:0] s4min);
    return (s0 < s0max) && (s4 > s4min);
  endfunction

endpackage

// File: rtl/gamma_phase_counter.sv
// rtl/gamma_phase_counter.sv - counts gamma cycle boundaries within one schedule phase
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cycle_start  one-clk gamma boundary pulse
//   clear        hold the count at zero
//   len          phase length in gamma cycles (>= 1)
//   last         high in the clk where cycle_start meets count == len-1
module gamma_phase_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cycle_start,
  input  logic       clear,
  input  logic [7:0] len,
  output logic       last
);

  logic [7:0] count;

  assign last = cycle_start && (count == (len - 8'd1));

  // The boundary that ends a phase also starts the next one, so the
  // counter wraps to zero by itself on last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear || last) begin
      count <= 8'd0;
    end else if (cycle_start) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/theta_train_sequencer.sv
// rtl/theta_train_sequencer.sv - gamma-aligned warm-up / A-B training / frozen evaluation scheduler
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cycle_start         gamma cycle boundary pulse
//   start, abort        run request (IDLE only) / return to IDLE (highest priority)
//   cur_a, cur_b        pattern A / B currents
//   slot0_dbg, slot4_dbg  slot values sampled for the verdict
//   input_current, l3_freeze  drive to the theta datapath
//   busy, done, pass    status: not IDLE / verdict strobe / held verdict
//   seg_idx, state_dbg  training segment index / FSM state
module theta_train_sequencer
  import theta_seq_pkg::*;
#(
  parameter int WARM_CYC = DEF_WARM_CYC,
  parameter int SEG_CYC  = DEF_SEG_CYC,
  parameter int N_SEG    = DEF_N_SEG,
  parameter int EVAL_CYC = DEF_EVAL_CYC,
  parameter int S0_MAX   = DEF_S0_MAX,
  parameter int S4_MIN   = DEF_S4_MIN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cycle_start,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cur_a,
  input  logic [7:0] cur_b,
  input  logic [7:0] slot0_dbg,
  input  logic [7:0] slot4_dbg,
  output logic [7:0] input_current,
  output logic       l3_freeze,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] seg_idx,
  output logic [2:0] state_dbg
);

  localparam logic [7:0] WARM_LEN = 8'(WARM_CYC);
  localparam logic [7:0] SEG_LEN  = 8'(SEG_CYC);
  localparam logic [7:0] EVAL_LEN = 8'(EVAL_CYC);
  localparam logic [3:0] LAST_SEG = 4'(N_SEG - 1);

  seq_state_t state, state_d;
  logic [7:0] cur_d;
  logic       frz_d, done_d, pass_d, busy_d;
  logic [3:0] seg_d;
  logic       cnt_clear, phase_last;
  logic [7:0] cnt_len;

  gamma_phase_counter u_phase (
    .clk         (clk),
    .rst_n       (rst_n),
    .cycle_start (cycle_start),
    .clear       (cnt_clear),
    .len         (cnt_len),
    .last        (phase_last)
  );

  always_comb begin
    state_d   = state;
    cur_d     = input_current;
    frz_d     = l3_freeze;
    seg_d     = seg_idx;
    done_d    = 1'b0;
    pass_d    = pass;
    cnt_clear = 1'b0;
    cnt_len   = WARM_LEN;

    if (abort) begin
      state_d   = S_IDLE;
      cur_d     = 8'd0;
      frz_d     = 1'b0;
      seg_d     = 4'd0;
      pass_d    = 1'b0;
      cnt_clear = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          cur_d     = 8'd0;
          frz_d     = 1'b0;
          cnt_clear = 1'b1;
          if (start) begin
            pass_d  = 1'b0;
            state_d = S_ARM;
          end
        end
        // A boundary in the same clk as start is never seen here, since
        // the FSM is still IDLE in that clk.
        S_ARM: begin
          cnt_clear = 1'b1;
          if (cycle_start) begin
            cur_d   = cur_a;
            state_d = S_WARMUP;
          end
        end
        // Every boundary re-samples the current pattern, so cur_a/cur_b
        // changes land on the next gamma boundary, never mid-cycle.
        S_WARMUP: begin
          cnt_len = WARM_LEN;
          if (cycle_start) cur_d = cur_a;
          if (phase_last) begin
            seg_d = 4'd0;
            if (N_SEG == 0) begin
              state_d = S_EVAL;
              frz_d   = 1'b1;
            end else begin
              state_d = S_TRAIN;
              cur_d   = cur_b;
            end
          end
        end
        S_TRAIN: begin
          cnt_len = SEG_LEN;
          if (cycle_start) cur_d = seg_idx[0] ? cur_a : cur_b;
          if (phase_last) begin
            if (seg_idx == LAST_SEG) begin
              state_d = S_EVAL;
              frz_d   = 1'b1;
              cur_d   = cur_a;
            end else begin
              seg_d = seg_idx + 4'd1;
              cur_d = seg_idx[0] ? cur_b : cur_a;
            end
          end
        end
        // The verdict is registered on the edge into CHECK so that pass is
        // already valid in the clk where done is high.
        S_EVAL: begin
          cnt_len = EVAL_LEN;
          if (cycle_start) cur_d = cur_a;
          if (phase_last) begin
            state_d = S_CHECK;
            done_d  = 1'b1;
            pass_d  = theta_pass(slot0_dbg, slot4_dbg, 8'(S0_MAX), 8'(S4_MIN));
          end
        end
        // CHECK behaves as IDLE for a start arriving with done, so a
        // back-to-back run loses no clk.
        S_CHECK: begin
          cur_d     = 8'd0;
          frz_d     = 1'b0;
          cnt_clear = 1'b1;
          state_d   = S_IDLE;
          if (start) begin
            pass_d  = 1'b0;
            state_d = S_ARM;
          end
        end
        default: begin
          state_d   = S_IDLE;
          cur_d     = 8'd0;
          frz_d     = 1'b0;
          cnt_clear = 1'b1;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      input_current <= 8'd0;
      l3_freeze     <= 1'b0;
      seg_idx       <= 4'd0;
      done          <= 1'b0;
      pass          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      input_current <= cur_d;
      l3_freeze     <= frz_d;
      seg_idx       <= seg_d;
      done          <= done_d;
      pass          <= pass_d;
      busy          <= busy_d;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_theta_train_sequencer.sv
// tb/tb_theta_train_sequencer.sv - directed self-checking bench for theta_train_sequencer
module tb_theta_train_sequencer;
  import theta_seq_pkg::*;

  localparam int CYC = 16;

  logic       clk = 1'b0, rst_n = 1'b0, cycle_start = 1'b0;
  logic       start = 1'b0, abort = 1'b0, start_s = 1'b0;
  logic [7:0] cur_a = 8'd200, cur_b = 8'd5, slot0 = 8'd0, slot4 = 8'd0;
  logic [7:0] input_current, ic_s;
  logic       l3_freeze, busy, done, pass, frz_s, busy_s, done_s, pass_s;
  logic [3:0] seg_idx, seg_s;
  logic [2:0] state_dbg, st_s;

  int n_vec = 0, n_bad = 0, gcnt = 0, bidx = -1;

  theta_train_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .cycle_start(cycle_start), .start(start), .abort(abort),
    .cur_a(cur_a), .cur_b(cur_b), .slot0_dbg(slot0), .slot4_dbg(slot4),
    .input_current(input_current), .l3_freeze(l3_freeze), .busy(busy), .done(done),
    .pass(pass), .seg_idx(seg_idx), .state_dbg(state_dbg)
  );

  theta_train_sequencer #(.WARM_CYC(1), .SEG_CYC(8), .N_SEG(0), .EVAL_CYC(1)) u_small (
    .clk(clk), .rst_n(rst_n), .cycle_start(cycle_start), .start(start_s), .abort(1'b0),
    .cur_a(cur_a), .cur_b(cur_b), .slot0_dbg(slot0), .slot4_dbg(slot4),
    .input_current(ic_s), .l3_freeze(frz_s), .busy(busy_s), .done(done_s),
    .pass(pass_s), .seg_idx(seg_s), .state_dbg(st_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s0;
    logic [7:0] s4;
    logic       exp_pass;
    bit         sched;
    bit         align;
  } run_t;

  run_t runs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clk: drive cycle_start for this clk, then sample 1ns after the edge.
  task automatic clk1();
    cycle_start = (gcnt == CYC - 1);
    @(posedge clk);
    #1;
    gcnt    = (gcnt + 1) % CYC;
    start   = 1'b0;
    start_s = 1'b0;
    abort   = 1'b0;
  endtask

  function automatic int exp_cur(input int b);
    if (b < 20) return 200;
    if (b < 68) return (((b - 20) / 8) % 2 == 0) ? 5 : 200;
    return 200;
  endfunction

  // Advance boundary by boundary (bidx = index of last boundary seen since arming).
  task automatic run_to(input int stop_b, input bit sched, input logic exp_pass, output int done_b);
    done_b = -1;
    for (int c = 0; c < 90 * CYC; c++) begin
      bit cs;
      cs = (gcnt == CYC - 1);
      if (sched && bidx == 30) start = 1'b1;
      clk1();
      if (cs) bidx++;
      if (bidx < 0) chk("arm_current", input_current, 0);
      if (cs && sched && bidx >= 0 && bidx < 76) begin
        chk("sched_current", input_current, exp_cur(bidx));
        chk("sched_freeze", l3_freeze, bidx >= 68);
        if (bidx >= 20 && bidx < 68) chk("sched_seg", seg_idx, (bidx - 20) / 8);
      end
      if (done) begin
        done_b = bidx;
        chk("done_pass", pass, exp_pass);
        return;
      end
      if (cs && bidx == stop_b) return;
    end
  endtask

  initial begin
    int db;
    bit seen;

    runs[0] = '{s0: 8'd1,  s4: 8'd40,  exp_pass: 1'b1, sched: 1'b1, align: 1'b1};
    runs[1] = '{s0: 8'd12, s4: 8'd40,  exp_pass: 1'b0, sched: 1'b0, align: 1'b0};
    runs[2] = '{s0: 8'd1,  s4: 8'd20,  exp_pass: 1'b0, sched: 1'b0, align: 1'b1};
    runs[3] = '{s0: 8'd10, s4: 8'd255, exp_pass: 1'b0, sched: 1'b0, align: 1'b0};
    runs[4] = '{s0: 8'd9,  s4: 8'd21,  exp_pass: 1'b1, sched: 1'b0, align: 1'b0};

    repeat (3) clk1();
    chk("rst_current", input_current, 0);
    chk("rst_freeze", l3_freeze, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_seg", seg_idx, 0);
    chk("rst_state", state_dbg, S_IDLE);
    rst_n = 1'b1;
    clk1();

    for (int i = 0; i < 5; i++) begin
      slot0 = runs[i].s0;
      slot4 = runs[i].s4;
      if (runs[i].align) begin
        while (gcnt != CYC - 1) clk1();
      end
      start = 1'b1;
      clk1();
      chk("start_state", state_dbg, S_ARM);
      chk("start_busy", busy, 1);
      if (runs[i].align) chk("coincident_current", input_current, 0);
      bidx = -1;
      run_to(-1, runs[i].sched, runs[i].exp_pass, db);
      chk("done_at", db, 76);
      if (i < 4) begin
        clk1();
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_current", input_current, 0);
        chk("post_freeze", l3_freeze, 0);
        chk("pass_held", pass, runs[i].exp_pass);
      end
    end

    // start in the done clk is accepted and clears the held verdict
    start = 1'b1;
    clk1();
    chk("done_clk_start", state_dbg, S_ARM);
    chk("start_clears_pass", pass, 0);
    bidx = -1;
    run_to(2, 1'b0, 1'b0, db);
    cur_a = 8'd150;
    clk1();
    clk1();
    chk("midphase_cur_a", input_current, 200);
    run_to(3, 1'b0, 1'b0, db);
    chk("boundary_cur_a", input_current, 150);
    cur_a = 8'd200;
    run_to(46, 1'b0, 1'b0, db);
    chk("reach_seg3", bidx, 46);
    chk("seg3_idx", seg_idx, 3);
    chk("seg3_current", input_current, 200);
    clk1();
    clk1();
    abort = 1'b1;
    clk1();
    chk("abort_busy", busy, 0);
    chk("abort_current", input_current, 0);
    chk("abort_freeze", l3_freeze, 0);
    chk("abort_seg", seg_idx, 0);
    chk("abort_pass", pass, 0);
    chk("abort_state", state_dbg, S_IDLE);
    seen = 1'b0;
    for (int c = 0; c < 80 * CYC; c++) begin
      clk1();
      if (done) seen = 1'b1;
    end
    chk("no_done_after_abort", seen, 0);

    // asynchronous reset in the middle of EVAL
    slot0 = 8'd1;
    slot4 = 8'd40;
    start = 1'b1;
    clk1();
    bidx = -1;
    run_to(70, 1'b0, 1'b0, db);
    chk("eval_reached", bidx, 70);
    chk("eval_freeze", l3_freeze, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_current", input_current, 0);
    chk("arst_freeze", l3_freeze, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    chk("arst_seg", seg_idx, 0);
    chk("arst_state", state_dbg, S_IDLE);
    #2;
    rst_n = 1'b1;
    clk1();

    // minimal schedule: one warm-up cycle, no training, one eval cycle
    start_s = 1'b1;
    clk1();
    chk("small_busy", busy_s, 1);
    bidx = -1;
    db = -1;
    for (int c = 0; c < 6 * CYC; c++) begin
      bit cs;
      cs = (gcnt == CYC - 1);
      clk1();
      if (cs) bidx++;
      if (cs && bidx == 0) begin
        chk("small_b0_current", ic_s, 200);
        chk("small_b0_freeze", frz_s, 0);
      end
      if (cs && bidx == 1) begin
        chk("small_b1_current", ic_s, 200);
        chk("small_b1_freeze", frz_s, 1);
      end
      if (done_s) begin
        db = bidx;
        chk("small_pass", pass_s, 1);
        break;
      end
    end
    chk("small_done_at", db, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
